bus_alu_sequencer: RTL and testbench

// Parametrised successor to the single-width ALU control FSM. Sequences one ALU instruction over the shared
// tri-state bus: read operand A from the register file, read operand B (register or zero-extended immediate),

---
 rtl/bus_alu_sequencer_pkg.sv | 38 +++
 rtl/bus_alu_sequencer_if.sv | 39 +++
 rtl/bus_alu_decode.sv | 31 +++
 rtl/bus_alu_sequencer.sv | 169 ++++++++++++++++
 tb/tb_bus_alu_sequencer.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_alu_sequencer_pkg.sv
// Shared constants for the bus ALU sequencer: opcode table, ALU select codes,
// FSM state encodings and the decoded-instruction record.
package bus_alu_sequencer_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_MOV = 4'd8;

    // ALU codes start at 1 so an idle alu_control of 0 never aliases a real operation
    localparam logic [3:0] ALU_ADD = 4'd1;
    localparam logic [3:0] ALU_SUB = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_XOR = 4'd5;
    localparam logic [3:0] ALU_NOT = 4'd6;
    localparam logic [3:0] ALU_SHL = 4'd7;
    localparam logic [3:0] ALU_SHR = 4'd8;
    localparam logic [3:0] ALU_MOV = 4'd9;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD_A = 3'd1;
    localparam logic [2:0] ST_RD_B = 3'd2;
    localparam logic [2:0] ST_EXEC = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    typedef struct packed {
        logic [3:0] alu_code;
        logic       unary;
        logic       illegal;
    } decode_t;

endpackage

// File: rtl/bus_alu_sequencer_if.sv
// Dispatcher-facing handshake plus register-file / ALU / immediate bus controls.
interface bus_alu_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6,
    parameter int OPC_W  = 4,
    parameter int CTRL_W = 4
);
    logic              start;
    logic [OPC_W-1:0]  opcode;
    logic [ADDR_W-1:0] param1;
    logic [ADDR_W-1:0] param2;
    logic              imm_en;
    logic              busy;
    logic              done;
    logic              illegal;
    logic [ADDR_W-1:0] register_addr;
    logic              bus_register_input_en;
    logic              bus_register_output_en;
    logic              latched_bus1_en;
    logic              latched_bus2_en;
    logic              alu_bus_out_en;
    logic [CTRL_W-1:0] alu_control;
    logic              imm_bus_out_en;
    logic [DATA_W-1:0] imm_bus_data;

    modport master (
        output start, opcode, param1, param2, imm_en,
        input  busy, done, illegal, register_addr, bus_register_input_en,
               bus_register_output_en, latched_bus1_en, latched_bus2_en,
               alu_bus_out_en, alu_control, imm_bus_out_en, imm_bus_data
    );

    modport slave (
        input  start, opcode, param1, param2, imm_en,
        output busy, done, illegal, register_addr, bus_register_input_en,
               bus_register_output_en, latched_bus1_en, latched_bus2_en,
               alu_bus_out_en, alu_control, imm_bus_out_en, imm_bus_data
    );
endinterface

// File: rtl/bus_alu_decode.sv
// Combinational opcode decoder: ALU select code, unary flag, illegal flag.
module bus_alu_decode
    import bus_alu_sequencer_pkg::*;
#(
    parameter int OPC_W = 4
) (
    input  logic [OPC_W-1:0] opcode,
    output decode_t          dec
);

    // Opcode table lookup; anything outside the table is flagged illegal
    always_comb begin
        dec = '{alu_code: 4'd0, unary: 1'b0, illegal: 1'b0};
        case (opcode)
            OPC_W'(OP_ADD): dec.alu_code = ALU_ADD;
            OPC_W'(OP_SUB): dec.alu_code = ALU_SUB;
            OPC_W'(OP_AND): dec.alu_code = ALU_AND;
            OPC_W'(OP_OR):  dec.alu_code = ALU_OR;
            OPC_W'(OP_XOR): dec.alu_code = ALU_XOR;
            OPC_W'(OP_NOT): begin
                dec.alu_code = ALU_NOT;
                dec.unary    = 1'b1;
            end
            OPC_W'(OP_SHL): dec.alu_code = ALU_SHL;
            OPC_W'(OP_SHR): dec.alu_code = ALU_SHR;
            OPC_W'(OP_MOV): dec.alu_code = ALU_MOV;
            default:        dec.illegal  = 1'b1;
        endcase
    end

endmodule

// File: rtl/bus_alu_sequencer.sv
// Sequences one ALU instruction over the shared bus: read A, read B (register or
// immediate), execute with write-back to param1, then a one-cycle done pulse.
module bus_alu_sequencer
    import bus_alu_sequencer_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 6,
    parameter int OPC_W       = 4,
    parameter int CTRL_W      = 4,
    parameter bit IMM_MODE_EN = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    bus_alu_sequencer_if.slave  bus
);

    logic [2:0]        state_r, state_nxt_s;
    decode_t           dec_s, dec_r, dec_nxt_s;
    logic [ADDR_W-1:0] p1_r, p1_nxt_s, p2_r, p2_nxt_s;
    logic              imm_r, imm_nxt_s;
    logic [DATA_W-1:0] imm_ext_s;

    logic              busy_r, done_r, illegal_r, rin_r, rout_r, l1_r, l2_r, aluout_r, immout_r;
    logic              busy_nxt_s, done_nxt_s, illegal_nxt_s, rin_nxt_s, rout_nxt_s;
    logic              l1_nxt_s, l2_nxt_s, aluout_nxt_s, immout_nxt_s;
    logic [ADDR_W-1:0] addr_r, addr_nxt_s;
    logic [CTRL_W-1:0] ctrl_r, ctrl_nxt_s;
    logic [DATA_W-1:0] imm_data_r;

    bus_alu_decode #(.OPC_W(OPC_W)) u_decode (
        .opcode (bus.opcode),
        .dec    (dec_s)
    );

    if (ADDR_W >= DATA_W) begin : g_imm_trunc
        assign imm_ext_s = p2_nxt_s[DATA_W-1:0];
    end else begin : g_imm_pad
        assign imm_ext_s = {{(DATA_W-ADDR_W){1'b0}}, p2_nxt_s};
    end

    // Next state and instruction latch; inputs are captured only on an accepted start
    always_comb begin
        state_nxt_s = state_r;
        dec_nxt_s   = dec_r;
        p1_nxt_s    = p1_r;
        p2_nxt_s    = p2_r;
        imm_nxt_s   = imm_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    dec_nxt_s   = dec_s;
                    p1_nxt_s    = bus.param1;
                    p2_nxt_s    = bus.param2;
                    imm_nxt_s   = bus.imm_en & IMM_MODE_EN;
                    state_nxt_s = dec_s.illegal ? ST_DONE : ST_RD_A;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD_A: state_nxt_s = dec_r.unary ? ST_EXEC : ST_RD_B;
            ST_RD_B: state_nxt_s = ST_EXEC;
            ST_EXEC: state_nxt_s = ST_DONE;
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode of the upcoming state so every output leaves a flop
    always_comb begin
        busy_nxt_s    = 1'b0;
        done_nxt_s    = 1'b0;
        illegal_nxt_s = 1'b0;
        rin_nxt_s     = 1'b0;
        rout_nxt_s    = 1'b0;
        l1_nxt_s      = 1'b0;
        l2_nxt_s      = 1'b0;
        aluout_nxt_s  = 1'b0;
        immout_nxt_s  = 1'b0;
        addr_nxt_s    = '0;
        ctrl_nxt_s    = '0;
        case (state_nxt_s)
            ST_IDLE: busy_nxt_s = 1'b0;
            ST_RD_A: begin
                busy_nxt_s = 1'b1;
                addr_nxt_s = p1_nxt_s;
                rout_nxt_s = 1'b1;
                l1_nxt_s   = 1'b1;
            end
            ST_RD_B: begin
                busy_nxt_s = 1'b1;
                l2_nxt_s   = 1'b1;
                if (imm_nxt_s) begin
                    immout_nxt_s = 1'b1;
                end else begin
                    addr_nxt_s = p2_nxt_s;
                    rout_nxt_s = 1'b1;
                end
            end
            ST_EXEC: begin
                busy_nxt_s   = 1'b1;
                ctrl_nxt_s   = CTRL_W'(dec_nxt_s.alu_code);
                aluout_nxt_s = 1'b1;
                addr_nxt_s   = p1_nxt_s;
                rin_nxt_s    = 1'b1;
            end
            ST_DONE: begin
                busy_nxt_s    = 1'b1;
                done_nxt_s    = 1'b1;
                illegal_nxt_s = dec_nxt_s.illegal;
            end
            default: busy_nxt_s = 1'b0;
        endcase
    end

    // State, latched instruction and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            dec_r      <= '{alu_code: 4'd0, unary: 1'b0, illegal: 1'b0};
            p1_r       <= '0;
            p2_r       <= '0;
            imm_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            illegal_r  <= 1'b0;
            rin_r      <= 1'b0;
            rout_r     <= 1'b0;
            l1_r       <= 1'b0;
            l2_r       <= 1'b0;
            aluout_r   <= 1'b0;
            immout_r   <= 1'b0;
            addr_r     <= '0;
            ctrl_r     <= '0;
            imm_data_r <= '0;
        end else begin
            state_r    <= state_nxt_s;
            dec_r      <= dec_nxt_s;
            p1_r       <= p1_nxt_s;
            p2_r       <= p2_nxt_s;
            imm_r      <= imm_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
            illegal_r  <= illegal_nxt_s;
            rin_r      <= rin_nxt_s;
            rout_r     <= rout_nxt_s;
            l1_r       <= l1_nxt_s;
            l2_r       <= l2_nxt_s;
            aluout_r   <= aluout_nxt_s;
            immout_r   <= immout_nxt_s;
            addr_r     <= addr_nxt_s;
            ctrl_r     <= ctrl_nxt_s;
            imm_data_r <= imm_ext_s;
        end
    end

    assign bus.busy                   = busy_r;
    assign bus.done                   = done_r;
    assign bus.illegal                = illegal_r;
    assign bus.register_addr          = addr_r;
    assign bus.bus_register_input_en  = rin_r;
    assign bus.bus_register_output_en = rout_r;
    assign bus.latched_bus1_en        = l1_r;
    assign bus.latched_bus2_en        = l2_r;
    assign bus.alu_bus_out_en         = aluout_r;
    assign bus.alu_control            = ctrl_r;
    assign bus.imm_bus_out_en         = immout_r;
    assign bus.imm_bus_data           = imm_data_r;

endmodule

// File: tb/tb_bus_alu_sequencer.sv
// Directed bench for bus_alu_sequencer: default configuration plus a wide,
// immediate-disabled instance driven with the same stimulus.
module tb_bus_alu_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    // Enable vector order: busy done illegal rin rout l1 l2 aluout immout
    localparam logic [8:0] E_IDLE     = 9'b000000000;
    localparam logic [8:0] E_RDA      = 9'b100011000;
    localparam logic [8:0] E_RDB_R    = 9'b100010100;
    localparam logic [8:0] E_RDB_I    = 9'b100000101;
    localparam logic [8:0] E_EXEC     = 9'b100100010;
    localparam logic [8:0] E_DONE     = 9'b110000000;
    localparam logic [8:0] E_DONE_ILL = 9'b111000000;
    localparam logic [3:0] A_ADD = 4'h1;
    localparam logic [3:0] A_SUB = 4'h2;
    localparam logic [3:0] A_NOT = 4'h6;

    logic [18:0] got_a;
    logic [20:0] got_b;
    logic [13:0] done_m, busy_m;
    logic        flag;

    bus_alu_sequencer_if #(.DATA_W(16), .ADDR_W(6), .OPC_W(4), .CTRL_W(4)) ifa ();
    bus_alu_sequencer_if #(.DATA_W(32), .ADDR_W(8), .OPC_W(4), .CTRL_W(4)) ifb ();

    bus_alu_sequencer #(.DATA_W(16), .ADDR_W(6), .OPC_W(4), .CTRL_W(4), .IMM_MODE_EN(1'b1)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (ifa)
    );

    bus_alu_sequencer #(.DATA_W(32), .ADDR_W(8), .OPC_W(4), .CTRL_W(4), .IMM_MODE_EN(1'b0)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (ifb)
    );

    always #5 clock = ~clock;

    function automatic logic [8:0] en_a();
        return {ifa.busy, ifa.done, ifa.illegal, ifa.bus_register_input_en, ifa.bus_register_output_en,
                ifa.latched_bus1_en, ifa.latched_bus2_en, ifa.alu_bus_out_en, ifa.imm_bus_out_en};
    endfunction

    function automatic logic [8:0] en_b();
        return {ifb.busy, ifb.done, ifb.illegal, ifb.bus_register_input_en, ifb.bus_register_output_en,
                ifb.latched_bus1_en, ifb.latched_bus2_en, ifb.alu_bus_out_en, ifb.imm_bus_out_en};
    endfunction

    // At most one bus driver per cycle on either instance
    always @(negedge clock) begin
        n_chk++;
        if ($countones({ifa.bus_register_output_en, ifa.alu_bus_out_en, ifa.imm_bus_out_en}) > 1 ||
            $countones({ifb.bus_register_output_en, ifb.alu_bus_out_en, ifb.imm_bus_out_en}) > 1) begin
            $display("FAIL bus_exclusive t=%0t got a=%b b=%b exp at most one driver", $time,
                     {ifa.bus_register_output_en, ifa.alu_bus_out_en, ifa.imm_bus_out_en},
                     {ifb.bus_register_output_en, ifb.alu_bus_out_en, ifb.imm_bus_out_en});
            n_fail++;
        end
    end

    task automatic tick();
        @(negedge clock);
        got_a = {en_a(), ifa.register_addr, ifa.alu_control};
        got_b = {en_b(), ifb.register_addr, ifb.alu_control};
    endtask

    task automatic set_in(input logic s, input logic [3:0] opc, input logic [5:0] a,
                          input logic [5:0] b, input logic im);
        ifa.start = s;  ifa.opcode = opc; ifa.param1 = a;  ifa.param2 = b;  ifa.imm_en = im;
        ifb.start = s;  ifb.opcode = opc; ifb.param1 = {2'b00, a}; ifb.param2 = {2'b00, b}; ifb.imm_en = im;
    endtask

    task automatic test_reset();
        set_in(1'b0, 4'h0, 6'd0, 6'd0, 1'b0);
        reset = 1'b0;
        #1;
        n_chk++;
        if ({en_a(), ifa.register_addr, ifa.alu_control, ifa.imm_bus_data} !== 35'd0) begin
            $display("FAIL reset_a got %h exp 0", {en_a(), ifa.register_addr, ifa.alu_control, ifa.imm_bus_data});
            n_fail++;
        end
        n_chk++;
        if ({en_b(), ifb.register_addr, ifb.alu_control, ifb.imm_bus_data} !== 53'd0) begin
            $display("FAIL reset_b got %h exp 0", {en_b(), ifb.register_addr, ifb.alu_control, ifb.imm_bus_data});
            n_fail++;
        end
        tick();
        reset = 1'b1;
        tick();
        n_chk++;
        if (got_a !== 19'd0) begin
            $display("FAIL reset_idle got %h exp 0", got_a);
            n_fail++;
        end
    endtask

    task automatic test_add_reg();
        set_in(1'b1, 4'h0, 6'd3, 6'd5, 1'b0);
        tick();
        n_chk++;
        if (got_a !== {E_RDA, 6'd3, 4'h0}) begin
            $display("FAIL add_reg_rd_a got %h exp %h", got_a, {E_RDA, 6'd3, 4'h0}); n_fail++;
        end
        set_in(1'b0, 4'h4, 6'd9, 6'd11, 1'b1);
        tick();
        n_chk++;
        if (got_a !== {E_RDB_R, 6'd5, 4'h0}) begin
            $display("FAIL add_reg_rd_b got %h exp %h", got_a, {E_RDB_R, 6'd5, 4'h0}); n_fail++;
        end
        tick();
        n_chk++;
        if (got_a !== {E_EXEC, 6'd3, A_ADD}) begin
            $display("FAIL add_reg_exec got %h exp %h", got_a, {E_EXEC, 6'd3, A_ADD}); n_fail++;
        end
        n_chk++;
        if (got_b !== {E_EXEC, 8'd3, A_ADD}) begin
            $display("FAIL add_reg_exec_b got %h exp %h", got_b, {E_EXEC, 8'd3, A_ADD}); n_fail++;
        end
        tick();
        n_chk++;
        if (got_a !== {E_DONE, 6'd0, 4'h0}) begin
            $display("FAIL add_reg_done got %h exp %h", got_a, {E_DONE, 6'd0, 4'h0}); n_fail++;
        end
        tick();
        n_chk++;
        if (got_a !== {E_IDLE, 6'd0, 4'h0}) begin
            $display("FAIL add_reg_idle got %h exp %h", got_a, {E_IDLE, 6'd0, 4'h0}); n_fail++;
        end
    endtask

    task automatic test_add_imm();
        set_in(1'b1, 4'h0, 6'd2, 6'h2A, 1'b1);
        tick();
        n_chk++;
        if (got_a !== {E_RDA, 6'd2, 4'h0}) begin
            $display("FAIL add_imm_rd_a got %h exp %h", got_a, {E_RDA, 6'd2, 4'h0}); n_fail++;
        end
        set_in(1'b0, 4'h0, 6'd0, 6'd0, 1'b0);
        tick();
        n_chk++;
        if ({got_a, ifa.imm_bus_data} !== {E_RDB_I, 6'd0, 4'h0, 16'h002A}) begin
            $display("FAIL add_imm_rd_b got %h exp %h", {got_a, ifa.imm_bus_data}, {E_RDB_I, 6'd0, 4'h0, 16'h002A});
            n_fail++;
        end
        n_chk++;
        if ({got_b, ifb.imm_bus_data} !== {E_RDB_R, 8'h2A, 4'h0, 32'h0000002A}) begin
            $display("FAIL imm_disabled_rd_b got %h exp %h", {got_b, ifb.imm_bus_data},
                     {E_RDB_R, 8'h2A, 4'h0, 32'h0000002A});
            n_fail++;
        end
        tick();
        n_chk++;
        if (got_a !== {E_EXEC, 6'd2, A_ADD}) begin
            $display("FAIL add_imm_exec got %h exp %h", got_a, {E_EXEC, 6'd2, A_ADD}); n_fail++;
        end
        tick();
        n_chk++;
        if (got_a !== {E_DONE, 6'd0, 4'h0}) begin
            $display("FAIL add_imm_done got %h exp %h", got_a, {E_DONE, 6'd0, 4'h0}); n_fail++;
        end
        tick();
    endtask

    task automatic test_not();
        set_in(1'b1, 4'h5, 6'd7, 6'd12, 1'b0);
        tick();
        n_chk++;
        if (got_a !== {E_RDA, 6'd7, 4'h0}) begin
            $display("FAIL not_rd_a got %h exp %h", got_a, {E_RDA, 6'd7, 4'h0}); n_fail++;
        end
        set_in(1'b0, 4'h0, 6'd0, 6'd0, 1'b0);
        tick();
        n_chk++;
        if (got_a !== {E_EXEC, 6'd7, A_NOT}) begin
            $display("FAIL not_exec got %h exp %h", got_a, {E_EXEC, 6'd7, A_NOT}); n_fail++;
        end
        tick();
        n_chk++;
        if (got_a !== {E_DONE, 6'd0, 4'h0}) begin
            $display("FAIL not_done got %h exp %h", got_a, {E_DONE, 6'd0, 4'h0}); n_fail++;
        end
        tick();
        n_chk++;
        if (got_a !== {E_IDLE, 6'd0, 4'h0}) begin
            $display("FAIL not_idle got %h exp %h", got_a, {E_IDLE, 6'd0, 4'h0}); n_fail++;
        end
    endtask

    task automatic test_illegal();
        set_in(1'b1, 4'hC, 6'd4, 6'd5, 1'b0);
        tick();
        n_chk++;
        if (got_a !== {E_DONE_ILL, 6'd0, 4'h0}) begin
            $display("FAIL illegal_done got %h exp %h", got_a, {E_DONE_ILL, 6'd0, 4'h0}); n_fail++;
        end
        n_chk++;
        if (got_b !== {E_DONE_ILL, 8'd0, 4'h0}) begin
            $display("FAIL illegal_done_b got %h exp %h", got_b, {E_DONE_ILL, 8'd0, 4'h0}); n_fail++;
        end
        set_in(1'b0, 4'h0, 6'd0, 6'd0, 1'b0);
        tick();
        n_chk++;
        if (got_a !== {E_IDLE, 6'd0, 4'h0}) begin
            $display("FAIL illegal_idle got %h exp %h", got_a, {E_IDLE, 6'd0, 4'h0}); n_fail++;
        end
    endtask

    task automatic test_busy_ignore();
        set_in(1'b1, 4'h1, 6'd1, 6'd2, 1'b0);
        tick();
        set_in(1'b1, 4'hC, 6'd6, 6'd6, 1'b1);
        tick();
        n_chk++;
        if (got_a !== {E_RDB_R, 6'd2, 4'h0}) begin
            $display("FAIL busy_ignore_rd_b got %h exp %h", got_a, {E_RDB_R, 6'd2, 4'h0}); n_fail++;
        end
        set_in(1'b0, 4'h0, 6'd0, 6'd0, 1'b0);
        tick();
        n_chk++;
        if (got_a !== {E_EXEC, 6'd1, A_SUB}) begin
            $display("FAIL busy_ignore_exec got %h exp %h", got_a, {E_EXEC, 6'd1, A_SUB}); n_fail++;
        end
        tick();
        n_chk++;
        if (got_a !== {E_DONE, 6'd0, 4'h0}) begin
            $display("FAIL busy_ignore_done got %h exp %h", got_a, {E_DONE, 6'd0, 4'h0}); n_fail++;
        end
        tick();
    endtask

    task automatic test_back_to_back();
        set_in(1'b1, 4'h1, 6'd1, 6'd2, 1'b0);
        for (int i = 1; i <= 14; i++) begin
            tick();
            done_m[i-1] = ifa.done;
            busy_m[i-1] = ifa.busy;
            if (i == 8) set_in(1'b0, 4'h0, 6'd0, 6'd0, 1'b0);
        end
        n_chk++;
        if (done_m !== 14'b00000100001000) begin
            $display("FAIL held_start_done got %b exp %b", done_m, 14'b00000100001000); n_fail++;
        end
        n_chk++;
        if (busy_m !== 14'b00000111101111) begin
            $display("FAIL held_start_busy got %b exp %b", busy_m, 14'b00000111101111); n_fail++;
        end
    endtask

    task automatic test_reset_mid();
        set_in(1'b1, 4'h0, 6'd3, 6'd5, 1'b0);
        tick();
        set_in(1'b0, 4'h0, 6'd0, 6'd0, 1'b0);
        tick();
        tick();
        n_chk++;
        if (got_a !== {E_EXEC, 6'd3, A_ADD}) begin
            $display("FAIL reset_mid_exec got %h exp %h", got_a, {E_EXEC, 6'd3, A_ADD}); n_fail++;
        end
        #2 reset = 1'b0;
        #1;
        n_chk++;
        if ({en_a(), ifa.register_addr, ifa.alu_control, ifa.imm_bus_data} !== 35'd0) begin
            $display("FAIL reset_mid_outputs got %h exp 0",
                     {en_a(), ifa.register_addr, ifa.alu_control, ifa.imm_bus_data});
            n_fail++;
        end
        tick();
        reset = 1'b1;
        flag = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (got_a !== 19'd0) flag = 1'b1;
        end
        n_chk++;
        if (flag !== 1'b0) begin
            $display("FAIL reset_mid_after got %h exp 0", got_a); n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_add_reg();
        test_add_imm();
        test_not();
        test_illegal();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
